// File: rtl/rom_fetch_unit.sv
// Instruction fetch controller: walks the fetch PC through the instruction ROM and
// buffers fetched words in a 2-entry queue presented to decode with valid/ready.
module rom_fetch_unit #(
   parameter int          PROFUNDIDAD = 1024,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   localparam int         AW          = $clog2(PROFUNDIDAD-1)
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          run,
   input  logic          redirect,
   input  logic [31:0]   redirect_pc,
   output logic [AW-1:0] rom_addr,
   input  logic [31:0]   rom_data,
   output logic          instr_valid,
   output logic [31:0]   instr,
   output logic [31:0]   instr_pc,
   input  logic          instr_ready,
   output logic [31:0]   instr_count
);

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_fetch_pc;
   logic [1:0]  r_cnt;
   logic [31:0] r_count;
   logic [31:0] r_q0_pc;
   logic [31:0] r_q0_word;
   logic [31:0] r_q1_pc;
   logic [31:0] r_q1_word;

   logic        w_fetch_en;
   logic        w_pop;
   logic        w_push;
   logic        w_wr_head;
   logic        w_in_range;
   logic [31:0] w_push_word;
   logic        w_unused_pc_bits;

   assign w_unused_pc_bits = &{1'b0, redirect_pc[1:0]};

   // The cycle after a redirect already fetches from the new PC, so FLUSH
   // allows a push just like FETCH; the redirect cycle itself never pushes.
   always_comb begin
      w_state_nxt = r_state;
      w_fetch_en  = 1'b0;
      case (r_state)
         IDLE:    if (run) w_state_nxt = FETCH;
         FETCH: begin
            w_fetch_en = 1'b1;
            if (!run) w_state_nxt = IDLE;
         end
         FLUSH: begin
            w_fetch_en  = 1'b1;
            w_state_nxt = run ? FETCH : IDLE;
         end
         default: w_state_nxt = FETCH;
      endcase
      if (redirect) w_state_nxt = FLUSH;
   end

   assign instr_valid = (r_cnt != 2'd0);
   assign instr       = instr_valid ? r_q0_word : 32'h0;
   assign instr_pc    = instr_valid ? r_q0_pc   : 32'h0;
   assign instr_count = r_count;
   assign rom_addr    = r_fetch_pc[AW+1:2];

   assign w_pop       = instr_valid && instr_ready && !redirect;
   assign w_push      = w_fetch_en && run && !redirect && ((r_cnt != 2'd2) || w_pop);
   assign w_in_range  = ({2'b00, r_fetch_pc[31:2]} < 32'(PROFUNDIDAD));
   assign w_push_word = w_in_range ? rom_data : NOP_WORD;
   // New entry lands at index (cnt - pop): head when the queue is or becomes empty.
   assign w_wr_head   = (r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state    <= FETCH;
         r_fetch_pc <= RESET_PC;
         r_cnt      <= 2'd0;
         r_count    <= 32'h0;
      end else begin
         r_state <= w_state_nxt;
         if (redirect) begin
            r_cnt      <= 2'd0;
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
         end else begin
            case ({w_push, w_pop})
               2'b10:   r_cnt <= r_cnt + 2'd1;
               2'b01:   r_cnt <= r_cnt - 2'd1;
               default: r_cnt <= r_cnt;
            endcase
            if (w_push) r_fetch_pc <= r_fetch_pc + 32'd4;
         end
         if (w_pop) r_count <= r_count + 32'd1;
      end
   end

   // Queue payload carries no reset; it is masked by r_cnt on the outputs.
   always_ff @(posedge CLK) begin
      if (w_pop) begin
         r_q0_pc   <= r_q1_pc;
         r_q0_word <= r_q1_word;
      end
      if (w_push) begin
         if (w_wr_head) begin
            r_q0_pc   <= r_fetch_pc;
            r_q0_word <= w_push_word;
         end else begin
            r_q1_pc   <= r_fetch_pc;
            r_q1_word <= w_push_word;
         end
      end
   end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed bench for rom_fetch_unit: a 1024-word instance and a 16-word instance
// backed by ROM models whose word i holds the value i.
module tb_rom_fetch_unit;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        run, redirect, instr_ready;
   logic [31:0] redirect_pc;
   logic [9:0]  rom_addr;
   logic [31:0] rom_data;
   logic        instr_valid;
   logic [31:0] instr, instr_pc, instr_count;

   logic        run2, redirect2, instr_ready2;
   logic [31:0] redirect_pc2;
   logic [3:0]  rom_addr2;
   logic [31:0] rom_data2;
   logic        instr_valid2;
   logic [31:0] instr2, instr_pc2, instr_count2;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   assign rom_data  = {22'b0, rom_addr};
   assign rom_data2 = {28'b0, rom_addr2};

   rom_fetch_unit #(.PROFUNDIDAD(1024), .RESET_PC(32'h0)) dut (
      .CLK(CLK), .RESET(RESET), .run(run), .redirect(redirect), .redirect_pc(redirect_pc),
      .rom_addr(rom_addr), .rom_data(rom_data), .instr_valid(instr_valid), .instr(instr),
      .instr_pc(instr_pc), .instr_ready(instr_ready), .instr_count(instr_count)
   );

   rom_fetch_unit #(.PROFUNDIDAD(16), .RESET_PC(32'h0)) dut16 (
      .CLK(CLK), .RESET(RESET), .run(run2), .redirect(redirect2), .redirect_pc(redirect_pc2),
      .rom_addr(rom_addr2), .rom_data(rom_data2), .instr_valid(instr_valid2), .instr(instr2),
      .instr_pc(instr_pc2), .instr_ready(instr_ready2), .instr_count(instr_count2)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Reset asserted mid-cycle, released just after an edge so the next edge is the first live one.
   task automatic do_reset(input logic r, input logic rdy);
      #2;
      RESET       = 1'b1;
      run         = r;
      instr_ready = rdy;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      run = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
      run2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = 32'h0; instr_ready2 = 1'b0;
      #3;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", instr_valid); end
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h expected 0", instr); end
      checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h expected 0", instr_pc); end
      checks++; if (instr_count !== 32'h0) begin errors++; $display("FAIL reset_count got %0d expected 0", instr_count); end
      checks++; if (rom_addr !== 10'd0) begin errors++; $display("FAIL reset_rom_addr got %h expected 0", rom_addr); end
      @(posedge CLK); #1;
      RESET = 1'b0;
   endtask

   task automatic test_stream();
      do_reset(1'b1, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         tick();
         checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid k=%0d got %b expected 1", k, instr_valid); end
         checks++; if (instr !== 32'(k-1)) begin errors++; $display("FAIL stream_instr k=%0d got %h expected %h", k, instr, 32'(k-1)); end
         checks++; if (instr_pc !== 32'(4*(k-1))) begin errors++; $display("FAIL stream_pc k=%0d got %h expected %h", k, instr_pc, 32'(4*(k-1))); end
         checks++; if (instr_count !== 32'(k-1)) begin errors++; $display("FAIL stream_count k=%0d got %0d expected %0d", k, instr_count, k-1); end
      end
   endtask

   task automatic test_backpressure();
      do_reset(1'b1, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         tick();
         checks++; if (instr_pc !== 32'h0 || instr_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_head k=%0d got valid=%b pc=%h expected valid=1 pc=0", k, instr_valid, instr_pc); end
      end
      checks++; if (rom_addr !== 10'd2) begin errors++; $display("FAIL bp_fetch_frozen got %h expected 2", rom_addr); end
      instr_ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++; if (instr_pc !== 32'(4*k)) begin errors++; $display("FAIL bp_drain_pc k=%0d got %h expected %h", k, instr_pc, 32'(4*k)); end
         checks++; if (instr !== 32'(k)) begin errors++; $display("FAIL bp_drain_instr k=%0d got %h expected %h", k, instr, 32'(k)); end
      end
      checks++; if (instr_count !== 32'd3) begin errors++; $display("FAIL bp_count got %0d expected 3", instr_count); end
   endtask

   task automatic test_redirect();
      do_reset(1'b1, 1'b0);
      tick();
      tick();
      instr_ready = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0103;
      tick();
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid got %b expected 0", instr_valid); end
      checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL redir_flush_count got %0d expected 0", instr_count); end
      checks++; if (rom_addr !== 10'h40) begin errors++; $display("FAIL redir_rom_addr got %h expected 040", rom_addr); end
      tick();
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL redir_valid got %b expected 1", instr_valid); end
      checks++; if (instr_pc !== 32'h100) begin errors++; $display("FAIL redir_pc got %h expected 00000100", instr_pc); end
      checks++; if (instr !== 32'd64) begin errors++; $display("FAIL redir_instr got %h expected 00000040", instr); end
      checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL redir_count got %0d expected 0", instr_count); end
      tick();
      checks++; if (instr_pc !== 32'h104 || instr !== 32'd65) begin errors++; $display("FAIL redir_next got pc=%h instr=%h expected pc=00000104 instr=00000041", instr_pc, instr); end
      checks++; if (instr_count !== 32'd1) begin errors++; $display("FAIL redir_next_count got %0d expected 1", instr_count); end
   endtask

   task automatic test_run_hold();
      do_reset(1'b1, 1'b0);
      tick();
      tick();
      run         = 1'b0;
      instr_ready = 1'b1;
      tick();
      checks++; if (instr_pc !== 32'h4 || instr_count !== 32'd1) begin errors++; $display("FAIL hold_drain1 got pc=%h count=%0d expected pc=00000004 count=1", instr_pc, instr_count); end
      tick();
      checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL hold_empty got valid=%b instr=%h pc=%h expected 0/0/0", instr_valid, instr, instr_pc); end
      checks++; if (instr_count !== 32'd2) begin errors++; $display("FAIL hold_count got %0d expected 2", instr_count); end
      tick();
      checks++; if (instr_valid !== 1'b0 || rom_addr !== 10'd2) begin errors++; $display("FAIL hold_frozen got valid=%b rom_addr=%h expected valid=0 rom_addr=2", instr_valid, rom_addr); end
      run         = 1'b1;
      instr_ready = 1'b0;
      tick();
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8 || instr !== 32'd2) begin errors++; $display("FAIL hold_resume got valid=%b pc=%h instr=%h expected 1/00000008/00000002", instr_valid, instr_pc, instr); end
   endtask

   task automatic test_nop();
      run2         = 1'b1;
      instr_ready2 = 1'b1;
      redirect2    = 1'b1;
      redirect_pc2 = 32'h38;
      tick();
      redirect2    = 1'b0;
      redirect_pc2 = 32'h0;
      checks++; if (instr_valid2 !== 1'b0) begin errors++; $display("FAIL nop_flush_valid got %b expected 0", instr_valid2); end
      tick();
      checks++; if (instr_pc2 !== 32'h38 || instr2 !== 32'd14) begin errors++; $display("FAIL nop_w38 got pc=%h instr=%h expected 00000038/0000000e", instr_pc2, instr2); end
      tick();
      checks++; if (instr_pc2 !== 32'h3C || instr2 !== 32'd15) begin errors++; $display("FAIL nop_w3c got pc=%h instr=%h expected 0000003c/0000000f", instr_pc2, instr2); end
      tick();
      checks++; if (instr_pc2 !== 32'h40 || instr2 !== 32'h13) begin errors++; $display("FAIL nop_w40 got pc=%h instr=%h expected 00000040/00000013", instr_pc2, instr2); end
      tick();
      checks++; if (instr_pc2 !== 32'h44 || instr2 !== 32'h13) begin errors++; $display("FAIL nop_w44 got pc=%h instr=%h expected 00000044/00000013", instr_pc2, instr2); end
      run2 = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset(1'b1, 1'b1);
      tick();
      tick();
      tick();
      checks++; if (instr_pc !== 32'h8 || instr_count !== 32'd2) begin errors++; $display("FAIL areset_pre got pc=%h count=%0d expected 00000008/2", instr_pc, instr_count); end
      #2;
      RESET = 1'b1;
      #1;
      checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL areset_outputs got valid=%b instr=%h pc=%h expected 0/0/0", instr_valid, instr, instr_pc); end
      checks++; if (instr_count !== 32'd0 || rom_addr !== 10'd0) begin errors++; $display("FAIL areset_state got count=%0d rom_addr=%h expected 0/0", instr_count, rom_addr); end
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h0) begin errors++; $display("FAIL areset_first got valid=%b pc=%h instr=%h expected 1/0/0", instr_valid, instr_pc, instr); end
      tick();
      checks++; if (instr_pc !== 32'h4 || instr_count !== 32'd1) begin errors++; $display("FAIL areset_second got pc=%h count=%0d expected 00000004/1", instr_pc, instr_count); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_run_hold();
      test_nop();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
